mips_seq_alu: RTL and testbench
===============================

// Module: mips_seq_alu
// PURPOSE
//  Next-generation execute unit for the MIPS datapath: parametrised-width ALU with a
//  valid/ready handshake and an iterative multiply/divide engine. The ALUFun encoding is
//  unchanged, and MUL/DIV are added. Single-cycle ops return one cycle after accept;
//  MUL/DIV stall the issuing stage via in_ready.
// PARAMETERS
//  WIDTH    32  operand/result width; >=8, power of two
//  SHW      $clog2(WIDTH)  shift-amount width (derived localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op valid this cycle
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  A          in   WIDTH  operand A (shift amount for SLL/SRL/SRA in A[SHW-1:0])
//  B          in   WIDTH  operand B
//  ALUFun     in   6      operation code
//  Sign       in   1      1 = signed compare/overflow/mul/div; 0 = unsigned
//  out_valid  out  1      result valid; held until out_valid & out_ready
//  out_ready  in   1      consumer accepts result
//  Z          out  WIDTH  result (MUL: low product; DIV: quotient)
//  Hi         out  WIDTH  MUL: high product; DIV: remainder; else 0
//  V          out  1      ADD/SUB overflow (Sign=1: two's-comp; Sign=0: carry/borrow); DIV MIN/-1
//  Zf         out  1      Z == 0
//  dz         out  1      DIV with B == 0
//  err        out  1      unsupported ALUFun
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; Z, Hi, V, Zf, dz and err = 0.
//  ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001,
//   A 011010, SLL 100000, SRL 100001, SRA 100011 (arithmetic on B), EQ 110011, NEQ 110001,
//   LT 110101, LEZ 111101, GEZ 111001, GTZ 111111. Compare ops return Z={0..,1} or 0 and
//   use signed/unsigned per Sign. LEZ/GEZ/GTZ test A against 0.
//   MUL 001000, DIV 001001. Any other code: Z=0, Hi=0, err=1, latency 1.
//  FSM: IDLE -> (accept single-cycle op) DONE; IDLE -> (accept MUL/DIV) BUSY;
//   BUSY -> DONE when the iteration counter reaches WIDTH-1; DONE -> IDLE on out_ready.
//   DONE also accepts a new op in the same cycle: in_ready = IDLE | (DONE & out_ready).
//  Latency (accept edge to out_valid): 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL/DIV.
//   The result register is written only at the completion edge. Outputs stay stable
//   while out_valid=1 and out_ready=0.
//  All operands are captured at accept. Later changes on A/B/ALUFun/Sign have no effect.
//  MUL: radix-2 shift-add on operand magnitudes. If Sign=1, the 2*WIDTH product is negated
//   when the operand signs differ. {Hi,Z}=product. V=0.
//  DIV: restoring, one quotient bit per cycle, on magnitudes. Sign=1: quotient truncates
//   toward zero; remainder takes the sign of A.
//   B==0: Z=all-ones, Hi=A, dz=1, and the unit still takes the full WIDTH+1 latency.
//   Sign=1, A=MIN, B=-1: Z=MIN, Hi=0, V=1.
//  Flags err, dz and V describe only the current result. They clear with the next result.
//  in_valid while BUSY is ignored (in_ready=0), and no operands are captured.
//  rst_n low at any time, including mid-BUSY, aborts the op, drops out_valid, returns to IDLE.
// STRUCTURE
//  Package mips_alu_pkg: ALUFun localparams (ALU_ADD..ALU_DIV), FSM state encoding
//   (S_IDLE, S_BUSY, S_DONE), is_multicycle(fun) function.
//  Sub-module mips_muldiv_iter: start/mul_ndiv/sign/A/B in; busy, done, lo, hi, dz, ovf out.
//   It owns the counter and the partial registers. The top owns the FSM, the combinational
//   ALU and the result register.
// TESTING (WIDTH=32 unless noted)
//  1 ADD Sign=1 A=7FFFFFFF B=1 -> Z=80000000 V=1, out_valid 1 cycle after accept;
//    same with Sign=0 -> V=0.
//  2 LT A=FFFFFFFF B=1: Sign=1 -> Z=1; Sign=0 -> Z=0. SRA A=4 B=80000000 -> Z=F8000000.
//  3 MUL Sign=1 A=-3 B=5 -> Z=FFFFFFF1 Hi=FFFFFFFF, out_valid exactly 33 cycles after accept;
//    in_ready=0 throughout.
//  4 DIV Sign=1 A=7 B=-2 -> Z=FFFFFFFD Hi=1. DIV B=0 A=9 -> Z=FFFFFFFF Hi=9 dz=1.
//    DIV A=80000000 B=FFFFFFFF -> V=1.
//  5 Back-to-back: 3 ADDs with out_ready=1 -> 3 results on 3 consecutive cycles.
//    Hold out_ready=0 for 4 cycles -> Z stable, in_ready=0.
//  6 Assert rst_n=0 at cycle 10 of a DIV -> out_valid=0 and in_ready=1 immediately.
//    A following ADD 2+3 -> Z=5.
//    Unknown ALUFun 000111 -> err=1 Z=0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared opcode map, FSM encoding and decode helper for the MIPS sequential ALU.
package mips_alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_GEZ = 6'b111001;
  localparam logic [5:0] ALU_GTZ = 6'b111111;
  localparam logic [5:0] ALU_MUL = 6'b001000;
  localparam logic [5:0] ALU_DIV = 6'b001001;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic is_multicycle(input logic [5:0] fun);
    return (fun == ALU_MUL) || (fun == ALU_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative multiply (radix-2 shift-add) / restoring divide on operand magnitudes.
// Sign fix-up is applied to the final-iteration value so results are ready on the done edge.
module mips_muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mul_ndiv,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic               busy_r, mode_mul, neg_lo, neg_hi, dz_r, ovf_r;
  logic [WIDTH-1:0]   acc, qr, dv, a_org;
  logic [WIDTH-1:0]   acc_nx, qr_nx;
  logic [WIDTH:0]     sum, r_sh, trial;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  // acc/qr hold {product hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum   = {1'b0, acc} + (qr[0] ? {1'b0, dv} : '0);
    r_sh  = {acc, qr[WIDTH-1]};
    trial = r_sh - {1'b0, dv};
    if (mode_mul) begin
      acc_nx = sum[WIDTH:1];
      qr_nx  = {sum[0], qr[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_nx = trial[WIDTH-1:0];
      qr_nx  = {qr[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = r_sh[WIDTH-1:0];
      qr_nx  = {qr[WIDTH-2:0], 1'b0};
    end
  end

  assign prod = {acc_nx, qr_nx};

  always_comb begin
    lo = '0;
    hi = '0;
    if (mode_mul) begin
      {hi, lo} = neg_lo ? -prod : prod;
    end else if (dz_r) begin
      lo = '1;
      hi = a_org;
    end else begin
      lo = neg_lo ? -qr_nx  : qr_nx;
      hi = neg_hi ? -acc_nx : acc_nx;
    end
  end

  assign done = busy_r && (cnt == CW'(WIDTH-1));
  assign busy = busy_r;
  assign dz   = dz_r;
  assign ovf  = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      cnt      <= '0;
      mode_mul <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      acc      <= '0;
      qr       <= '0;
      dv       <= '0;
      a_org    <= '0;
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt      <= '0;
      mode_mul <= mul_ndiv;
      acc      <= '0;
      qr       <= mag(a, sign);
      dv       <= mag(b, sign);
      a_org    <= a;
      neg_lo   <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi   <= sign && a[WIDTH-1] && !mul_ndiv;
      dz_r     <= !mul_ndiv && (b == '0);
      ovf_r    <= !mul_ndiv && sign && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end else if (busy_r) begin
      acc <= acc_nx;
      qr  <= qr_nx;
      cnt <= cnt + 1'b1;
      if (done) busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_seq_alu.sv
// MIPS execute unit: single-cycle combinational ALU plus iterative MUL/DIV behind a
// valid/ready handshake. The result register is written only on the completion edge.
module mips_seq_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Hi,
  output logic             V,
  output logic             Zf,
  output logic             dz,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] hi;
    logic             v;
    logic             zf;
    logic             dz;
    logic             err;
  } res_t;

  state_t           state, state_nx;
  res_t             res, alu_res, it_res;
  logic             accept, is_mc, it_start, it_busy, it_done, it_dz, it_ovf;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   sh;

  mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (it_start),
    .mul_ndiv (ALUFun == ALU_MUL),
    .sign     (Sign),
    .a        (A),
    .b        (B),
    .busy     (it_busy),
    .done     (it_done),
    .lo       (it_lo),
    .hi       (it_hi),
    .dz       (it_dz),
    .ovf      (it_ovf)
  );

  always_comb begin
    alu_res = '0;
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    sh      = A[SHW-1:0];
    case (ALUFun)
      ALU_ADD: begin
        alu_res.z = sum[M:0];
        alu_res.v = Sign ? ((A[M] == B[M]) && (sum[M] != A[M])) : sum[WIDTH];
      end
      ALU_SUB: begin
        alu_res.z = diff[M:0];
        alu_res.v = Sign ? ((A[M] != B[M]) && (diff[M] != A[M])) : diff[WIDTH];
      end
      ALU_AND: alu_res.z = A & B;
      ALU_OR:  alu_res.z = A | B;
      ALU_XOR: alu_res.z = A ^ B;
      ALU_NOR: alu_res.z = ~(A | B);
      ALU_A:   alu_res.z = A;
      ALU_SLL: alu_res.z = B << sh;
      ALU_SRL: alu_res.z = B >> sh;
      ALU_SRA: alu_res.z = $signed(B) >>> sh;
      ALU_EQ:  alu_res.z = WIDTH'(A == B);
      ALU_NEQ: alu_res.z = WIDTH'(A != B);
      ALU_LT:  alu_res.z = WIDTH'(Sign ? ($signed(A) < $signed(B)) : (A < B));
      ALU_LEZ: alu_res.z = WIDTH'(Sign ? (A[M] || (A == '0)) : (A == '0));
      ALU_GEZ: alu_res.z = WIDTH'(Sign ? !A[M] : 1'b1);
      ALU_GTZ: alu_res.z = WIDTH'(Sign ? (!A[M] && (A != '0)) : (A != '0));
      ALU_MUL, ALU_DIV: ;
      default: alu_res.err = 1'b1;
    endcase
    alu_res.zf = (alu_res.z == '0);
  end

  assign it_res = '{z: it_lo, hi: it_hi, v: it_ovf, zf: (it_lo == '0), dz: it_dz, err: 1'b0};

  assign is_mc     = is_multicycle(ALUFun);
  assign in_ready  = ((state == S_IDLE) || ((state == S_DONE) && out_ready)) && !it_busy;
  assign accept    = in_valid && in_ready;
  assign it_start  = accept && is_mc;
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = is_mc ? S_BUSY : S_DONE;
      S_BUSY:  if (it_done) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = accept ? (is_mc ? S_BUSY : S_DONE) : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      res   <= '0;
    end else begin
      state <= state_nx;
      if (accept && !is_mc)             res <= alu_res;
      else if ((state == S_BUSY) && it_done) res <= it_res;
    end
  end

  assign Z   = res.z;
  assign Hi  = res.hi;
  assign V   = res.v;
  assign Zf  = res.zf;
  assign dz  = res.dz;
  assign err = res.err;

endmodule

// File: tb/tb_mips_seq_alu.sv
// Directed bench for mips_seq_alu: arithmetic reference model + per-cycle scoreboard,
// plus literal expectations for the key corner cases.
module tb_mips_seq_alu;
  localparam int W = 32;

  logic           clk = 1'b0, rst_n = 1'b1;
  logic           in_valid = 1'b0, out_ready = 1'b1, Sign = 1'b0;
  logic [W-1:0]   A = '0, B = '0;
  logic [5:0]     ALUFun = '0;
  logic           in_ready, out_valid, V, Zf, dz, err;
  logic [W-1:0]   Z, Hi;
  int             n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  mips_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .Hi(Hi), .V(V), .Zf(Zf), .dz(dz), .err(err)
  );

  typedef struct {
    logic [W-1:0] z, hi;
    logic         v, zf, dz, err;
    int           lat, acc;
    bit           seen;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference: what the result must be, from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, r;
    logic [63:0] p;
    int n;
    e = '{default: 0};
    e.lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = int'(a[4:0]);
    case (f)
      6'b000000: begin
        r = s ? sa + sb : longint'(a) + longint'(b);
        e.z = r[31:0];
        e.v = s ? (r > 64'sd2147483647 || r < -64'sd2147483648) : r[32];
      end
      6'b000001: begin
        r = s ? sa - sb : longint'(a) - longint'(b);
        e.z = r[31:0];
        e.v = s ? (r > 64'sd2147483647 || r < -64'sd2147483648) : (a < b);
      end
      6'b011000: e.z = a & b;
      6'b011110: e.z = a | b;
      6'b010110: e.z = a ^ b;
      6'b010001: e.z = ~(a | b);
      6'b011010: e.z = a;
      6'b100000: e.z = b << n;
      6'b100001: e.z = b >> n;
      6'b100011: begin r = sb >>> n; e.z = r[31:0]; end
      6'b110011: e.z = (a == b) ? 1 : 0;
      6'b110001: e.z = (a != b) ? 1 : 0;
      6'b110101: e.z = (s ? (sa < sb) : (a < b)) ? 1 : 0;
      6'b111101: e.z = (s ? (sa <= 0) : (a == 0)) ? 1 : 0;
      6'b111001: e.z = (s ? (sa >= 0) : 1'b1) ? 1 : 0;
      6'b111111: e.z = (s ? (sa > 0) : (a != 0)) ? 1 : 0;
      6'b001000: begin
        e.lat = W + 1;
        if (s) begin r = sa * sb; p = r; end
        else p = {32'b0, a} * {32'b0, b};
        {e.hi, e.z} = p;
      end
      6'b001001: begin
        e.lat = W + 1;
        if (b == 0) begin
          e.z = '1; e.hi = a; e.dz = 1'b1;
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.z = a; e.hi = 0; e.v = 1'b1;
        end else if (s) begin
          r = sa / sb; e.z = r[31:0];
          r = sa % sb; e.hi = r[31:0];
        end else begin
          e.z = a / b; e.hi = a % b;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.zf = (e.z == 0);
    return e;
  endfunction

  // Scoreboard: inputs are stable by the falling edge, so everything is sampled there.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_z_hi", {Z, Hi}, 0);
      chk("rst_flags", {V, Zf, dz, err}, 0);
    end else begin
      chk("in_ready", in_ready, (q.size() == 0) || (out_valid && out_ready));
      if (q.size() > 0 && !q[0].seen && (cyc - q[0].acc) > q[0].lat) begin
        n_cmp++; n_bad++;
        $display("FAIL result_timeout: got no out_valid after %0d cycles required %0d", cyc - q[0].acc, q[0].lat);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_out_valid: got 1 required 0");
        end else begin
          if (!q[0].seen) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            q[0].seen = 1'b1;
          end
          chk("Z", Z, q[0].z);
          chk("Hi", Hi, q[0].hi);
          chk("flags_vzfdzerr", {V, Zf, dz, err}, {q[0].v, q[0].zf, q[0].dz, q[0].err});
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(ALUFun, Sign, A, B);
        mon_e.acc = cyc;
        q.push_back(mon_e);
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    ALUFun = f; Sign = s; A = a; B = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #2; n++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUFun = 6'($urandom); Sign = 1'($urandom);
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #2; lat++; end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_timeout: out_valid got 0 required 1");
    end
  endtask

  task automatic run(input string nm, input logic [5:0] f, input logic s,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ez, input logic [W-1:0] ehi,
                     input logic [2:0] efl, input int elat);
    int lat;
    issue(f, s, a, b);
    wait_res(lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_z"}, Z, ez);
    chk({nm, "_hi"}, Hi, ehi);
    chk({nm, "_v_dz_err"}, {V, dz, err}, efl);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    run("add_s_ovf",  6'b000000, 1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 3'b100, 1);
    run("add_u",      6'b000000, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 3'b000, 1);
    run("sub_u_brw",  6'b000001, 0, 32'h1, 32'h2, 32'hFFFFFFFF, 0, 3'b100, 1);
    run("lt_s",       6'b110101, 1, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 3'b000, 1);
    run("lt_u",       6'b110101, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 3'b000, 1);
    run("sra",        6'b100011, 0, 32'h4, 32'h80000000, 32'hF8000000, 0, 3'b000, 1);
    run("mul_s",      6'b001000, 1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 32'hFFFFFFFF, 3'b000, 33);
    run("mul_u_max",  6'b001000, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 3'b000, 33);
    run("div_s",      6'b001001, 1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 3'b000, 33);
    run("div_z",      6'b001001, 0, 32'h9, 32'h0, 32'hFFFFFFFF, 32'h9, 3'b010, 33);
    run("div_minm1",  6'b001001, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 3'b100, 33);

    // back-to-back single-cycle ops
    ALUFun = 6'b000000; Sign = 0; A = 1; B = 1; in_valid = 1'b1;
    @(posedge clk); #2;
    chk("b2b0_valid", out_valid, 1); chk("b2b0_z", Z, 2);
    A = 2; B = 2;
    @(posedge clk); #2;
    chk("b2b1_valid", out_valid, 1); chk("b2b1_z", Z, 4);
    A = 3; B = 3;
    @(posedge clk); #2;
    chk("b2b2_valid", out_valid, 1); chk("b2b2_z", Z, 6);
    in_valid = 1'b0;
    @(posedge clk); #2;

    // consumer stall
    out_ready = 1'b0;
    issue(6'b000000, 0, 32'd10, 32'd20);
    for (int i = 0; i < 4; i++) begin
      chk("hold_z", Z, 30);
      chk("hold_in_ready", in_ready, 0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;

    // reset in the middle of a divide
    issue(6'b001001, 0, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    run("add_post_rst", 6'b000000, 0, 32'd2, 32'd3, 32'd5, 0, 3'b000, 1);
    run("bad_fun",      6'b000111, 0, 32'h1234, 32'h5678, 32'h0, 0, 3'b001, 1);

    repeat (3) @(posedge clk);
    #2 chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no end of test required end before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
